// File: rtl/card_dealer_pkg.sv
// Shared types and constant helpers for the card dealer: FSM state
// encoding, maximal-length LFSR tap masks and derived-width functions.
package card_dealer_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SEARCH,
    S_PRESENT,
    S_EMPTY
  } state_e;

  // Fibonacci XOR tap masks (bit n-1 set for tap n), maximal length for 8..16.
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_cards);
    return width_of(num_cards);
  endfunction

  function automatic int unsigned rank_w(input int unsigned num_ranks);
    return width_of(num_ranks);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned num_cards);
    return $clog2(num_cards + 1);
  endfunction

  function automatic int unsigned suit_w(input int unsigned num_cards,
                                         input int unsigned num_ranks);
    return width_of(num_cards / num_ranks);
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Fibonacci LFSR. A zero seed is replaced by 1,
// and an all-zero state (unreachable in normal operation) is forced back to it.
module lfsr_gen
  import card_dealer_pkg::*;
#(
  parameter int unsigned        LFSR_W = 8,
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(8'hFF)
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [LFSR_W-1:0] Q
);

  localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Shift left, feedback from the tapped bits into bit 0.
  always_comb begin
    if (lfsr_q == '0) lfsr_d = INIT;
    else              lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  end

  // State register, advances every non-reset cycle.
  always_ff @(posedge CLK) begin
    if (RST) lfsr_q <= INIT;
    else     lfsr_q <= lfsr_d;
  end

  assign Q = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deck dealer: draws cards without replacement using an LFSR start index and a
// bounded wrap-around linear probe, presented on a CARD_VLD/ACK handshake.
// Optional macro CARD_DEALER_SUIT_EN adds a registered SUIT output.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int unsigned       NUM_CARDS = 52,
  parameter int unsigned       NUM_RANKS = 13,
  parameter int unsigned       LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(8'hFF),
  localparam int unsigned      IDX_W     = idx_w(NUM_CARDS),
  localparam int unsigned      RANK_W    = rank_w(NUM_RANKS),
  localparam int unsigned      CNT_W     = cnt_w(NUM_CARDS),
  localparam int unsigned      SUIT_W    = suit_w(NUM_CARDS, NUM_RANKS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SHUFFLE,
  input  logic              ACK,
  output logic              CARD_VLD,
  output logic [RANK_W-1:0] CARD,
  output logic [CNT_W-1:0]  REMAINING,
  output logic              EMPTY
`ifdef CARD_DEALER_SUIT_EN
  ,
  output logic [SUIT_W-1:0] SUIT
`endif
);

  state_e                 state_q, state_d;
  logic [NUM_CARDS-1:0]   deck_q, deck_d;
  logic [IDX_W-1:0]       cand_q, cand_d;
  logic [RANK_W-1:0]      card_q, card_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [LFSR_W-1:0]      lfsr;
  logic [IDX_W-1:0]       load_idx;
  logic                   hit;
  logic                   lfsr_unused;
  logic [RANK_W-1:0]      rank_lut [NUM_CARDS];

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .Q   (lfsr)
  );

  // Upper LFSR bits only feed the recurrence inside lfsr_gen.
  assign lfsr_unused = ^(lfsr >> IDX_W);

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_rank_lut
    assign rank_lut[i] = RANK_W'(i % NUM_RANKS);
  end

`ifdef CARD_DEALER_SUIT_EN
  logic [SUIT_W-1:0] suit_q, suit_d;
  logic [SUIT_W-1:0] suit_lut [NUM_CARDS];

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_suit_lut
    assign suit_lut[i] = SUIT_W'(i / NUM_RANKS);
  end
`endif

  // Fold the raw LFSR slice into deck range; one subtraction suffices.
  always_comb begin
    load_idx = lfsr[IDX_W-1:0];
    if ({1'b0, load_idx} >= (IDX_W+1)'(NUM_CARDS))
      load_idx = load_idx - IDX_W'(NUM_CARDS);
  end

  assign hit = deck_q[cand_q];

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // FSM next state; SHUFFLE overrides any ACK-driven transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    state_d = S_SEARCH;
      S_SEARCH:  if (hit) state_d = S_PRESENT;
      S_PRESENT: if (ACK) state_d = (rem_q != '0) ? S_LOAD : S_EMPTY;
      S_EMPTY:   state_d = S_EMPTY;
      default:   state_d = S_LOAD;
    endcase
    if (SHUFFLE) state_d = S_LOAD;
  end

  // FSM outputs decoded from state.
  always_comb begin
    CARD_VLD = (state_q == S_PRESENT);
    EMPTY    = (state_q == S_EMPTY);
  end

  // Datapath next values: candidate probe, deck bit, card and count on a hit.
  always_comb begin
    deck_d = deck_q;
    cand_d = cand_q;
    card_d = card_q;
    rem_d  = rem_q;
`ifdef CARD_DEALER_SUIT_EN
    suit_d = suit_q;
`endif
    case (state_q)
      S_LOAD: cand_d = load_idx;
      S_SEARCH: begin
        if (hit) begin
          deck_d[cand_q] = 1'b0;
          card_d         = rank_lut[cand_q];
          rem_d          = rem_q - CNT_W'(1);
`ifdef CARD_DEALER_SUIT_EN
          suit_d         = suit_lut[cand_q];
`endif
        end else begin
          cand_d = (cand_q == IDX_W'(NUM_CARDS - 1)) ? '0 : cand_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    if (SHUFFLE) begin
      deck_d = '1;
      rem_d  = CNT_W'(NUM_CARDS);
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deck_q <= '1;
      cand_q <= '0;
      card_q <= '0;
      rem_q  <= CNT_W'(NUM_CARDS);
    end else begin
      deck_q <= deck_d;
      cand_q <= cand_d;
      card_q <= card_d;
      rem_q  <= rem_d;
    end
  end

`ifdef CARD_DEALER_SUIT_EN
  // Suit register, updated alongside CARD.
  always_ff @(posedge CLK) begin
    if (RST) suit_q <= '0;
    else     suit_q <= suit_d;
  end

  assign SUIT = suit_q;
`endif

  assign CARD      = card_q;
  assign REMAINING = rem_q;

endmodule
